// File: rtl/traffic_lights_cmd_seq.sv
// traffic_lights_cmd_seq: turns host START/STOP/RECONFIG requests into traffic_lights cmd_type/cmd_valid/cmd_data.
// Define TL_CMD_SEQ_SKIP_UNCHANGED_EN to skip phase-time writes whose value matches the last one written.
module traffic_lights_cmd_seq #(
   parameter int GAP_CYC       = 2,
   parameter int MODE_HOLD_CYC = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_op_i,
   input  logic [15:0] req_red_i,
   input  logic [15:0] req_yellow_i,
   input  logic [15:0] req_green_i,
   output logic [2:0]  cmd_type_o,
   output logic        cmd_valid_o,
   output logic [15:0] cmd_data_o,
   output logic        running_o,
   output logic        err_o
);
   localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1;
   typedef enum logic [3:0] {S_IDLE, S_HOLD, S_PULSE, S_GAP, S_WR_G, S_WR_R, S_WR_Y, S_RESUME, S_ACK} state_t;
   state_t r_state, w_next;
   logic [1:0]  r_op, r_stage;
   logic [15:0] r_red, r_yel, r_grn, r_cnt;
   logic        r_running, r_err;
   logic        w_accept, w_bad, w_cnt_done, w_need_g, w_need_r, w_need_y;
   state_t      w_from_g, w_from_r, w_from_y;

   assign w_accept    = req_valid_i && (r_state == S_IDLE);
   assign w_bad       = (req_op_i == 2'd3) ||
                        ((req_op_i != OP_STOP) && (req_red_i == '0 || req_yellow_i == '0 || req_green_i == '0));
   assign w_cnt_done  = (r_state == S_HOLD) ? (r_cnt == 16'(MODE_HOLD_CYC - 1)) : (r_cnt == 16'(GAP_CYC - 1));
   assign req_ready_o = (r_state == S_IDLE);
   assign running_o   = r_running;
   assign err_o       = r_err;

`ifdef TL_CMD_SEQ_SKIP_UNCHANGED_EN
   logic [15:0] r_sh_r, r_sh_y, r_sh_g;
   assign w_need_g = (r_grn != r_sh_g);
   assign w_need_r = (r_red != r_sh_r);
   assign w_need_y = (r_yel != r_sh_y);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sh_r <= '0;
         r_sh_y <= '0;
         r_sh_g <= '0;
      end else begin
         if (r_state == S_WR_G) r_sh_g <= r_grn;
         if (r_state == S_WR_R) r_sh_r <= r_red;
         if (r_state == S_WR_Y) r_sh_y <= r_yel;
      end
   end
`else
   assign w_need_g = 1'b1;
   assign w_need_r = 1'b1;
   assign w_need_y = 1'b1;
`endif

   // Write chain in fixed G, R, Y order; skipped writes fall through to the next one.
   assign w_from_y = w_need_y ? S_WR_Y : S_RESUME;
   assign w_from_r = w_need_r ? S_WR_R : w_from_y;
   assign w_from_g = w_need_g ? S_WR_G : w_from_r;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      cmd_valid_o = 1'b0;
      cmd_type_o  = 3'd0;
      cmd_data_o  = '0;
      unique case (r_state)
         S_IDLE: if (req_valid_i)
            w_next = w_bad ? S_ACK :
                     (req_op_i == OP_START) ? (r_running ? S_ACK : S_PULSE) :
                     (req_op_i == OP_STOP)  ? (r_running ? S_HOLD : S_ACK) :
                     (r_running ? S_HOLD : S_PULSE);
         S_HOLD: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = (r_op == OP_STOP) ? 3'd1 : 3'd2;
            if (w_cnt_done) w_next = (r_op == OP_STOP) ? S_IDLE : S_GAP;
         end
         S_PULSE: begin
            cmd_valid_o = 1'b1;
            w_next      = S_GAP;
         end
         S_GAP: if (w_cnt_done)
            w_next = (r_stage == 2'd0) ? w_from_g : (r_stage == 2'd1) ? w_from_r :
                     (r_stage == 2'd2) ? w_from_y : S_RESUME;
         S_WR_G: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = 3'd3;
            cmd_data_o  = r_grn;
            w_next      = S_GAP;
         end
         S_WR_R: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = 3'd4;
            cmd_data_o  = r_red;
            w_next      = S_GAP;
         end
         S_WR_Y: begin
            cmd_valid_o = 1'b1;
            cmd_type_o  = 3'd5;
            cmd_data_o  = r_yel;
            w_next      = S_GAP;
         end
         S_RESUME: begin
            cmd_valid_o = 1'b1;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_op      <= '0;
         r_red     <= '0;
         r_yel     <= '0;
         r_grn     <= '0;
         r_cnt     <= '0;
         r_stage   <= '0;
         r_running <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op  <= req_op_i;
            r_red <= req_red_i;
            r_yel <= req_yellow_i;
            r_grn <= req_green_i;
         end
         r_err <= w_accept && w_bad;
         r_cnt <= (w_next == r_state) ? r_cnt + 16'd1 : '0;
         if (w_next == S_GAP && r_state != S_GAP)
            r_stage <= (r_state == S_WR_G) ? 2'd1 : (r_state == S_WR_R) ? 2'd2 : (r_state == S_WR_Y) ? 2'd3 : 2'd0;
         if (w_next == S_RESUME)
            r_running <= 1'b1;
         else if (w_accept && w_next == S_HOLD && req_op_i == OP_STOP)
            r_running <= 1'b0;
      end
   end
endmodule
